fdct_8x8_block: RTL and testbench

//  Forward 8x8 DCT engine for the encode path, the transform inverse of the milestone-3 IDCT stage.
//  On start, reads one 8x8 block of 8-bit samples (packed 2/word) from SRAM and computes S' = C*S*C^T in two 8-MAC passes.

---
 rtl/fdct_8x8_block.sv | 175 +++++++++++++++++
 tb/tb_fdct_8x8_block.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fdct_8x8_block.sv
// Forward 8x8 DCT: fetches a packed 8-bit sample block from SRAM, computes C*S*C^T
// with one shared MAC in two passes and writes 64 saturated 16-bit coefficients back.
`timescale 1ns/1ps
module fdct_8x8_block #(
   parameter int unsigned ROW_STRIDE = 160,
   parameter int unsigned SRAM_LAT   = 2
) (
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        start,
   input  logic [17:0] src_base,
   input  logic [17:0] dst_base,
   input  logic [15:0] SRAM_read_data,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PASS1, S_PASS2, S_DONE} state_t;

   localparam logic [9:0] FETCH_LAST = 10'(31 + SRAM_LAT);

   state_t             state;
   logic [17:0]        src_q, dst_q;
   logic [9:0]         cnt;
   logic               last_wr;
   logic [7:0]         s_mem [64];
   logic signed [31:0] t_mem [64];
   logic signed [47:0] acc;

   logic [9:0]         cnt_nx;
   logic [4:0]         cap;
   logic [2:0]         a_hi, a_mid, a_lo;
   logic [17:0]        rd_addr;
   logic signed [15:0] coef;
   logic signed [47:0] prod, sum, p2_shr;
   logic signed [15:0] sat;

   // Q12 cosine ROM; truncated magnitudes keep every row k>=1 summing to zero
   function automatic logic signed [15:0] crom(input logic [2:0] k, input logic [2:0] j);
      logic [4:0]         m, f;
      logic signed [15:0] v;
      m = 5'({1'b0, j, 1'b1} * {2'b0, k});
      f = (m > 5'd16) ? 5'(6'd32 - {1'b0, m}) : m;
      case (f)
         5'd1:    v =  16'sd2008;
         5'd2:    v =  16'sd1892;
         5'd3:    v =  16'sd1702;
         5'd4:    v =  16'sd1448;
         5'd5:    v =  16'sd1137;
         5'd6:    v =  16'sd783;
         5'd7:    v =  16'sd399;
         5'd9:    v = -16'sd399;
         5'd10:   v = -16'sd783;
         5'd11:   v = -16'sd1137;
         5'd12:   v = -16'sd1448;
         5'd13:   v = -16'sd1702;
         5'd14:   v = -16'sd1892;
         5'd15:   v = -16'sd2008;
         5'd16:   v = -16'sd2048;
         default: v =  16'sd0;
      endcase
      if (k == 3'd0) v = 16'sd1448;
      return v;
   endfunction

   // cnt fields: PASS1 = {i,k,j}, PASS2 = {k,l,i}
   always_comb begin
      cnt_nx  = cnt + 10'd1;
      cap     = 5'(cnt - 10'(SRAM_LAT));
      a_hi    = cnt[8:6];
      a_mid   = cnt[5:3];
      a_lo    = cnt[2:0];
      rd_addr = src_q + 18'(cnt_nx[4:2]) * 18'(ROW_STRIDE) + 18'(cnt_nx[1:0]);
      if (state == S_PASS2) begin
         coef = crom(a_hi, a_lo);
         prod = 48'(coef) * 48'(t_mem[{a_lo, a_mid}]);
      end else begin
         coef = crom(a_mid, a_lo);
         prod = 48'(coef) * 48'($signed({1'b0, s_mem[{a_hi, a_lo}]}));
      end
      sum    = acc + prod;
      p2_shr = sum >>> 16;
      if (p2_shr > 48'sd32767)
         sat = 16'sh7FFF;
      else if (p2_shr < -48'sd32768)
         sat = 16'sh8000;
      else
         sat = p2_shr[15:0];
   end

   always_ff @(posedge CLOCK_50_I) begin
      if (!resetn) begin
         state           <= S_IDLE;
         SRAM_we_n       <= 1'b1;
         SRAM_address    <= '0;
         SRAM_write_data <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         cnt             <= '0;
         acc             <= '0;
         last_wr         <= 1'b0;
         src_q           <= '0;
         dst_q           <= '0;
      end else begin
         SRAM_we_n <= 1'b1;
         done      <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  src_q        <= src_base;
                  dst_q        <= dst_base;
                  SRAM_address <= src_base;
                  cnt          <= '0;
                  last_wr      <= 1'b0;
                  busy         <= 1'b1;
                  state        <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (cnt_nx < 10'd32) SRAM_address <= rd_addr;
               if (cnt >= 10'(SRAM_LAT)) begin
                  s_mem[{cap, 1'b0}] <= SRAM_read_data[15:8];
                  s_mem[{cap, 1'b1}] <= SRAM_read_data[7:0];
               end
               if (cnt == FETCH_LAST) begin
                  cnt   <= '0;
                  acc   <= '0;
                  state <= S_PASS1;
               end else begin
                  cnt <= cnt_nx;
               end
            end
            S_PASS1: begin
               if (a_lo == 3'd7) begin
                  t_mem[{a_hi, a_mid}] <= 32'(sum >>> 8);
                  acc                  <= '0;
               end else begin
                  acc <= sum;
               end
               if (cnt == 10'd511) begin
                  cnt   <= '0;
                  state <= S_PASS2;
               end else begin
                  cnt <= cnt_nx;
               end
            end
            S_PASS2: begin
               // one extra cycle so the final write is on the bus before DONE
               if (last_wr) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  if (a_lo == 3'd7) begin
                     SRAM_we_n       <= 1'b0;
                     SRAM_address    <= dst_q + 18'({a_hi, a_mid});
                     SRAM_write_data <= sat;
                     acc             <= '0;
                  end else begin
                     acc <= sum;
                  end
                  if (cnt == 10'd511) last_wr <= 1'b1;
                  cnt <= cnt_nx;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fdct_8x8_block.sv
// Directed bench for fdct_8x8_block: floating-point-derived cosine table and plain
// integer arithmetic give the expected coefficients; every SRAM write is checked in order.
`timescale 1ns/1ps
module tb_fdct_8x8_block;

   logic        CLOCK_50_I = 1'b0;
   logic        resetn     = 1'b0;
   logic        start      = 1'b0;
   logic [17:0] src_base   = '0;
   logic [17:0] dst_base   = '0;
   logic [15:0] SRAM_read_data;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic        busy;
   logic        done;

   fdct_8x8_block #(.ROW_STRIDE(160), .SRAM_LAT(2)) dut (
      .CLOCK_50_I      (CLOCK_50_I),
      .resetn          (resetn),
      .start           (start),
      .src_base        (src_base),
      .dst_base        (dst_base),
      .SRAM_read_data  (SRAM_read_data),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n),
      .busy            (busy),
      .done            (done)
   );

   always #10 CLOCK_50_I = ~CLOCK_50_I;

   // SRAM with two-cycle read latency
   logic [15:0] mem [262144];
   logic [15:0] rd_p0, rd_p1;
   always @(posedge CLOCK_50_I) begin
      rd_p0 <= mem[SRAM_address];
      rd_p1 <= rd_p0;
   end
   assign SRAM_read_data = rd_p1;

   int vectors     = 0;
   int miscompares = 0;
   int cm [8][8];
   int blk [64];
   int expc [64];
   int ref_lat = -1;

   task automatic chk(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic build_c();
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++)
            cm[k][j] = (k == 0) ? 1448 :
               $rtoi(2048.0 * $cos(real'((2 * j + 1) * k) * 3.141592653589793 / 16.0));
   endtask

   task automatic model();
      longint t [8][8];
      longint a;
      for (int i = 0; i < 8; i++)
         for (int k = 0; k < 8; k++) begin
            a = 0;
            for (int j = 0; j < 8; j++) a += longint'(blk[i * 8 + j]) * cm[k][j];
            t[i][k] = a >>> 8;
         end
      for (int k = 0; k < 8; k++)
         for (int l = 0; l < 8; l++) begin
            a = 0;
            for (int i = 0; i < 8; i++) a += longint'(cm[k][i]) * t[i][l];
            a = a >>> 16;
            if (a > 32767) a = 32767;
            if (a < -32768) a = -32768;
            expc[k * 8 + l] = int'(a);
         end
   endtask

   task automatic load(input int src);
      logic [17:0] ad;
      for (int r = 0; r < 8; r++)
         for (int w = 0; w < 4; w++) begin
            ad = 18'(src + r * 160 + w);
            mem[ad] = {8'(blk[r * 8 + 2 * w]), 8'(blk[r * 8 + 2 * w + 1])};
         end
   endtask

   // mode 0: plain run; 1: extra start pulse mid-PASS1; 2: one-cycle reset mid-PASS2
   task automatic run(input int src, input int dst, input int mode);
      int widx = 0;
      int c;
      int nw;
      bit seen = 0;
      model();
      load(src);
      @(negedge CLOCK_50_I);
      src_base = 18'(src);
      dst_base = 18'(dst);
      start    = 1'b1;
      for (c = 0; c < 1200; c++) begin
         @(negedge CLOCK_50_I);
         start = 1'b0;
         if (mode == 1 && c == 200) start = 1'b1;
         if (c < 32) chk("rd_addr", SRAM_address, (src + (c / 4) * 160 + c % 4) & 'h3FFFF);
         if (c == 0) chk("busy_rise", busy, 1);
         if (!SRAM_we_n) begin
            if (widx < 64) begin
               chk("wr_addr", SRAM_address, (dst + widx) & 'h3FFFF);
               chk("wr_data", $signed(SRAM_write_data), expc[widx]);
            end else begin
               chk("extra_write", widx, 63);
            end
            widx++;
         end
         if (mode == 2 && c == 700) begin
            resetn = 1'b0;
            @(negedge CLOCK_50_I);
            resetn = 1'b1;
            chk("rst_we_n", SRAM_we_n, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            nw = 0;
            for (int q = 0; q < 60; q++) begin
               @(negedge CLOCK_50_I);
               if (!SRAM_we_n || busy || done) nw++;
            end
            chk("post_rst_activity", nw, 0);
            return;
         end
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk("done_seen", seen, 1);
      if (seen) begin
         chk("done_busy_low", busy, 0);
         chk("write_count", widx, 64);
         chk("latency_bound", (c <= 1100), 1);
         if (ref_lat < 0) ref_lat = c;
         else chk("latency_equal", c, ref_lat);
         @(negedge CLOCK_50_I);
         chk("done_pulse_width", done, 0);
      end
   endtask

   task automatic rand_blk();
      for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
   endtask

   initial begin
      int row1 [8];
      row1 = '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008};
      build_c();
      for (int j = 0; j < 8; j++) chk("crom_row1", cm[1][j], row1[j]);

      repeat (3) @(negedge CLOCK_50_I);
      chk("reset_we_n", SRAM_we_n, 1);
      chk("reset_addr", SRAM_address, 0);
      chk("reset_wdata", SRAM_write_data, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      resetn = 1'b1;

      // flat 128 block: only DC survives
      for (int i = 0; i < 64; i++) blk[i] = 128;
      model();
      chk("model_dc128", expc[0], 1023);
      chk("model_ac128", expc[9], 0);
      run(0, 'h01000, 0);

      // all-zero block, source and destination both wrap past 2^18
      for (int i = 0; i < 64; i++) blk[i] = 0;
      run('h3FF00, 'h3FFE0, 0);

      // alternating columns 0,255,...
      for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 1) ? 255 : 0;
      model();
      chk("model_alt_dc", expc[0], 1019);
      chk("model_alt_c7", expc[7], -924);
      chk("model_alt_row1", expc[8], 0);
      run(2000, 'h02000, 0);

      // identical block with and without a stray start mid-PASS1
      rand_blk();
      run(1000, 'h20000, 0);
      run(1000, 'h20000, 1);

      // abort mid-PASS2, then a normal run
      rand_blk();
      run(1000, 'h20000, 2);
      rand_blk();
      run(1000, 'h20000, 0);

      for (int n = 0; n < 36; n++) begin
         rand_blk();
         run(1000, 'h20000, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
